fifo_stream_reader: RTL

Read-side engine for the 8-bit synchronous FIFO. Owns the FIFO read port (`r_enable`/`empty`/`r_data`), absorbs its one-cycle read latency, and presents bytes on a valid/ready stream with burst framing (`m_last`). Sits between the byte FIFO and downstream consumers (serializers, packers). It sustains one byte per cycle under no backpressure and never loses or duplicates a byte under backpressure.

---
 rtl/fifo_rd_pkg.sv | 21 ++
 rtl/fifo_rd_skid.sv | 55 +++++
 rtl/fifo_stream_reader.sv | 94 +++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// ----------------------------------------------------------------------------
// fifo_rd_pkg : shared widths and buffer-entry type for the FIFO stream reader
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fifo_rd_pkg;

  localparam int DATA_W    = 8;
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = 16;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } rd_entry_t;

endpackage

`default_nettype wire

// File: rtl/fifo_rd_skid.sv
// ----------------------------------------------------------------------------
// fifo_rd_skid : 2-entry in-order output buffer; head register drives the stream
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_rd_skid
  import fifo_rd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  rd_entry_t        push_entry,
  input  logic             pop,
  output logic [OCC_W-1:0] cnt,
  output rd_entry_t        head
);

  localparam logic [OCC_W-1:0] FULL = OCC_W'(BUF_DEPTH);

  rd_entry_t tail;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == '0) head <= push_entry;
          else           tail <= push_entry;
          cnt <= cnt + OCC_W'(1);
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - OCC_W'(1);
        end
        2'b11: begin
          // Occupancy is unchanged; the new byte lands behind whatever remains.
          if (cnt == FULL) begin
            head <= tail;
            tail <= push_entry;
          end else begin
            head <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// fifo_stream_reader : FIFO read port -> valid/ready byte stream with burst framing
// Optional delivered-byte counter enabled by `define FIFO_RD_CNT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int BURST_LEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              fifo_empty,
  output logic              fifo_r_enable,
  input  logic [DATA_W-1:0] fifo_r_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [CNT_W-1:0]  byte_count
);

  localparam int               BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [8:0]        LEN9      = 9'(BURST_LEN);
  localparam logic [8:0]        LAST9     = 9'(BURST_LEN - 1);

  logic              inflight;
  logic [OCC_W-1:0]  cnt;
  logic [BEAT_W-1:0] beat;
  logic              hs;
  logic [2:0]        occ;
  logic [8:0]        idx_raw;
  logic [8:0]        idx_1;
  logic [8:0]        idx_2;
  rd_entry_t         cap_entry;
  rd_entry_t         head;

  assign hs      = m_valid && m_ready;
  assign m_valid = (cnt != '0);
  assign occ     = 3'(cnt) + 3'(inflight);

  assign fifo_r_enable = !reset && en && !fifo_empty && (occ < (3'd2 + 3'(hs)));

  // Incoming byte's position = bytes already delivered in this burst plus bytes
  // still buffered ahead of it; two subtractions cover BURST_LEN=1 with cnt=2.
  assign idx_raw = 9'(beat) + 9'(cnt);
  assign idx_1   = (idx_raw >= LEN9) ? idx_raw - LEN9 : idx_raw;
  assign idx_2   = (idx_1   >= LEN9) ? idx_1   - LEN9 : idx_1;

  assign cap_entry.data = fifo_r_data;
  assign cap_entry.last = (idx_2 == LAST9);

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= 1'b0;
      beat     <= '0;
    end else begin
      inflight <= fifo_r_enable && !fifo_empty;
      if (hs) beat <= (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);
    end
  end

  fifo_rd_skid u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (inflight),
    .push_entry (cap_entry),
    .pop        (hs),
    .cnt        (cnt),
    .head       (head)
  );

  assign m_data = head.data;
  assign m_last = head.last;

`ifdef FIFO_RD_CNT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset)   count_q <= '0;
    else if (hs) count_q <= count_q + CNT_W'(1);
  end

  assign byte_count = count_q;
`else
  assign byte_count = '0;
`endif

endmodule

`default_nettype wire
